// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-port, word-addressed data memory.
// Port 0 has fixed priority; port 1 is forced through after MAX_WAIT contended losses.
module dmem_arbiter_port #(
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_gnt,
  input  logic          i_we,
  input  logic          i_oor,
  input  logic [DW-1:0] i_rd,
  output logic          o_rvalid,
  output logic [DW-1:0] o_rdata,
  output logic          o_err
);
  logic          r_rvalid;
  logic [DW-1:0] r_rdata;
  logic          r_err;

  // rdata/err only move on a grant so a losing port keeps its last response
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= i_gnt;
      if (i_gnt) begin
        r_rdata <= (i_we | i_oor) ? '0 : i_rd;
        r_err   <= i_oor;
      end
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;
  assign o_err    = r_err;
endmodule

module dmem_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int DEPTH    = 64,
  parameter int MAX_WAIT = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_p0_req,
  input  logic          i_p0_we,
  input  logic [AW-1:0] i_p0_addr,
  input  logic [DW-1:0] i_p0_wdata,
  output logic          o_p0_gnt,
  output logic          o_p0_rvalid,
  output logic [DW-1:0] o_p0_rdata,
  output logic          o_p0_err,
  input  logic          i_p1_req,
  input  logic          i_p1_we,
  input  logic [AW-1:0] i_p1_addr,
  input  logic [DW-1:0] i_p1_wdata,
  output logic          o_p1_gnt,
  output logic          o_p1_rvalid,
  output logic [DW-1:0] o_p1_rdata,
  output logic          o_p1_err,
  output logic [AW-1:0] o_mem_A,
  output logic [DW-1:0] o_mem_WD,
  output logic          o_mem_WE,
  input  logic [DW-1:0] i_mem_RD
);
  localparam int NP = 2;
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [AW-1:0] LP_DEPTH = AW'(DEPTH);
  localparam logic [CW-1:0] LP_MAXW  = CW'(MAX_WAIT);

  logic [NP-1:0]         w_req, w_we, w_gnt, w_rvalid, w_err;
  logic [NP-1:0][AW-1:0] w_addr;
  logic [NP-1:0][DW-1:0] w_wdata, w_rdata;
  logic                  w_any, w_win, w_force1, w_sel_we, w_oor;
  logic [AW-1:0]         w_sel_addr;
  logic [DW-1:0]         w_sel_wdata;
  logic [CW-1:0]         r_wait_cnt;

  assign w_req   = {i_p1_req,   i_p0_req};
  assign w_we    = {i_p1_we,    i_p0_we};
  assign w_addr  = {i_p1_addr,  i_p0_addr};
  assign w_wdata = {i_p1_wdata, i_p0_wdata};

  assign w_force1 = (r_wait_cnt == LP_MAXW);
  assign w_gnt[1] = w_req[1] & (~w_req[0] | w_force1);
  assign w_gnt[0] = w_req[0] & ~w_gnt[1];
  assign w_any    = |w_gnt;
  assign w_win    = w_gnt[1];

  // idle cycles park the memory bus at zero
  assign w_sel_addr  = w_any ? w_addr[w_win]  : '0;
  assign w_sel_wdata = w_any ? w_wdata[w_win] : '0;
  assign w_sel_we    = w_any & w_we[w_win];
  assign w_oor       = (w_sel_addr >= LP_DEPTH);

  assign o_mem_A  = w_sel_addr;
  assign o_mem_WD = w_sel_wdata;
  assign o_mem_WE = w_sel_we & ~w_oor;
  assign o_p0_gnt = w_gnt[0];
  assign o_p1_gnt = w_gnt[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_wait_cnt <= '0;
    else if (w_req[1] & ~w_gnt[1] & w_req[0])
      r_wait_cnt <= w_force1 ? r_wait_cnt : r_wait_cnt + CW'(1);
    else
      r_wait_cnt <= '0;
  end

  for (genvar g = 0; g < NP; g++) begin : g_port
    dmem_arbiter_port #(.DW(DW)) u_port (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_gnt    (w_gnt[g]),
      .i_we     (w_sel_we),
      .i_oor    (w_oor),
      .i_rd     (i_mem_RD),
      .o_rvalid (w_rvalid[g]),
      .o_rdata  (w_rdata[g]),
      .o_err    (w_err[g])
    );
  end

  assign o_p0_rvalid = w_rvalid[0];
  assign o_p0_rdata  = w_rdata[0];
  assign o_p0_err    = w_err[0];
  assign o_p1_rvalid = w_rvalid[1];
  assign o_p1_rdata  = w_rdata[1];
  assign o_p1_err    = w_err[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic against a
// cycle-level reference model; responses are checked by a separate monitor.
module tb_dmem_arbiter;
  localparam int DW = 32, AW = 32, DEPTH = 64, MAX_WAIT = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic          p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err, mem_WE;
  logic [DW-1:0] p0_rdata, p1_rdata, mem_WD, mem_RD;
  logic [AW-1:0] mem_A;

  dmem_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
    .o_p0_gnt(p0_gnt), .o_p0_rvalid(p0_rvalid), .o_p0_rdata(p0_rdata), .o_p0_err(p0_err),
    .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
    .o_p1_gnt(p1_gnt), .o_p1_rvalid(p1_rvalid), .o_p1_rdata(p1_rdata), .o_p1_err(p1_err),
    .o_mem_A(mem_A), .o_mem_WD(mem_WD), .o_mem_WE(mem_WE), .i_mem_RD(mem_RD)
  );

  always #5 clk = ~clk;

  // memory attached to the DUT bus
  logic [DW-1:0] tbmem [DEPTH];
  assign mem_RD = (mem_A < AW'(DEPTH)) ? tbmem[mem_A[5:0]] : 32'hBAD0_BAD0;
  always @(posedge clk) if (mem_WE && mem_A < AW'(DEPTH)) tbmem[mem_A[5:0]] <= mem_WD;

  // reference model state
  logic [DW-1:0] refmem [DEPTH];
  logic [32:0]   q0[$], q1[$];
  logic [DW-1:0] last_rd [2];
  logic          last_er [2];
  int            losses;
  bit            g0_m, g1_m;
  int            total = 0, bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // one cycle: drive at negedge, check combinational outputs, predict response
  task automatic step(input bit r0, w0, input logic [31:0] a0, d0,
                      input bit r1, w1, input logic [31:0] a1, d1);
    bit we, oor;
    logic [31:0] a, d, rd;
    @(negedge clk);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    #1;
    g1_m = r1 && (!r0 || losses == MAX_WAIT);
    g0_m = r0 && !g1_m;
    check("p0_gnt", 64'(p0_gnt), 64'(g0_m));
    check("p1_gnt", 64'(p1_gnt), 64'(g1_m));
    if (g0_m || g1_m) begin
      we = g1_m ? w1 : w0;
      a  = g1_m ? a1 : a0;
      d  = g1_m ? d1 : d0;
      oor = (a >= DEPTH);
      rd = (we || oor) ? 32'h0 : refmem[a[5:0]];
      check("mem_A",  64'(mem_A),  64'(a));
      check("mem_WD", 64'(mem_WD), 64'(d));
      check("mem_WE", 64'(mem_WE), 64'(we && !oor));
      if (g1_m) q1.push_back({oor, rd}); else q0.push_back({oor, rd});
      if (we && !oor) refmem[a[5:0]] = d;
    end else begin
      check("idle_mem_A",  64'(mem_A),  64'h0);
      check("idle_mem_WD", 64'(mem_WD), 64'h0);
      check("idle_mem_WE", 64'(mem_WE), 64'h0);
    end
    losses = (r1 && !g1_m) ? ((losses == MAX_WAIT) ? MAX_WAIT : losses + 1) : 0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic mon(input int p, input bit rv, input logic [31:0] rd, input bit er);
    logic [32:0] e;
    bit has;
    has = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
    check($sformatf("p%0d_rvalid", p), 64'(rv), 64'(has));
    if (has) begin
      e = (p == 0) ? q0.pop_front() : q1.pop_front();
      last_rd[p] = e[31:0];
      last_er[p] = e[32];
    end
    check($sformatf("p%0d_rdata", p), 64'(rd), 64'(last_rd[p]));
    check($sformatf("p%0d_err", p),   64'(er), 64'(last_er[p]));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      mon(0, p0_rvalid, p0_rdata, p0_err);
      mon(1, p1_rvalid, p1_rdata, p1_err);
    end
  end

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 7))
      6:       return 32'(56 + $urandom_range(0, 15));
      7:       return $urandom;
      default: return 32'($urandom_range(0, 7));
    endcase
  endfunction

  bit          cr0, cw0, cr1, cw1;
  logic [31:0] ca0, cd0, ca1, cd1;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      refmem[i] = $urandom;
      tbmem[i]  = refmem[i];
    end
    last_rd[0] = 0; last_rd[1] = 0; last_er[0] = 0; last_er[1] = 0;
    losses = 0;
    #3;
    check("rst_p0_rvalid", 64'(p0_rvalid), 0);
    check("rst_p1_rvalid", 64'(p1_rvalid), 0);
    check("rst_p0_rdata",  64'(p0_rdata),  0);
    check("rst_p1_err",    64'(p1_err),    0);
    check("rst_gnt",       64'({p1_gnt, p0_gnt}), 0);
    check("rst_mem_A",     64'(mem_A), 0);
    @(negedge clk); rst_n = 1'b1;

    // port 0 write then read-after-write
    step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    step(1, 0, 5, 0,            0, 0, 0, 0);
    idle(); idle();

    // both ports contending: port 1 gets every fifth slot
    for (int k = 0; k < 15; k++) begin
      step(1, 0, 32'(k % 8), 0, 1, 0, 7, 0);
      check("starve_pattern", 64'(p1_gnt), 64'(k % 5 == 4));
    end
    idle();

    // port 1 alone at the top word
    step(0, 0, 0, 0, 1, 1, 63, 32'h12345678);
    step(0, 0, 0, 0, 1, 0, 63, 0);
    idle();

    // out-of-range write and read
    step(1, 1, 64, 32'hCAFEF00D, 0, 0, 0, 0);
    step(1, 0, 64, 0,            0, 0, 0, 0);
    idle();

    // reset while a grant is active and a response is outstanding
    for (int k = 0; k < 3; k++) step(1, 0, 2, 0, 1, 0, 3, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_p0_rvalid", 64'(p0_rvalid), 0);
    check("arst_p0_rdata",  64'(p0_rdata),  0);
    check("arst_p0_err",    64'(p0_err),    0);
    q0.delete(); q1.delete();
    last_rd[0] = 0; last_rd[1] = 0; last_er[0] = 0; last_er[1] = 0;
    losses = 0;
    @(negedge clk);
    p0_req = 0; p1_req = 0;
    @(negedge clk); rst_n = 1'b1;
    // wait count restarts from zero after reset
    for (int k = 0; k < 5; k++) step(1, 0, 1, 0, 1, 0, 4, 0);

    // quiet bus
    for (int k = 0; k < 10; k++) idle();

    // random traffic; a losing port holds its request stable
    cr0 = 0; cr1 = 0; cw0 = 0; cw1 = 0; ca0 = 0; ca1 = 0; cd0 = 0; cd1 = 0;
    for (int k = 0; k < 400; k++) begin
      if (!(cr0 && !g0_m)) begin
        cr0 = ($urandom_range(0, 3) != 0); cw0 = $urandom_range(0, 1) == 1;
        ca0 = rnd_addr(); cd0 = $urandom;
      end
      if (!(cr1 && !g1_m)) begin
        cr1 = ($urandom_range(0, 2) != 0); cw1 = $urandom_range(0, 1) == 1;
        ca1 = rnd_addr(); cd1 = $urandom;
      end
      step(cr0, cw0, ca0, cd0, cr1, cw1, ca1, cd1);
    end
    idle(); idle(); idle();
    check("q0_drained", 64'(q0.size()), 0);
    check("q1_drained", 64'(q1.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
